// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//   EX stage of a 5-stage 64-bit pipeline. It selects forwarded operands,
//   optionally replaces operand B with the immediate, runs the ALU, and
//   drives combinational zero and less-than flags to the branch logic.
//   The EX/MEM pipeline register captures the ALU result, the store data,
//   the destination register, PC+4 and the MEM/WB control bits.
//
// Ports
//   clk, reset_n                  clock, async active-low reset
//   ReadData1/2                   register-file operands A/B
//   DataMemWB, WriteBackWB        forwarded values from MEM and WB
//   ForwCntrl1/2                  forward selects for A/B
//   ALUSrcID, ImmOrDestID         immediate select and immediate value
//   ALUOp                         ALU operation
//   WriteRegID, LinkerRegisterDataID, *RegisterID / LinkerRegIdEx  -> EX/MEM
//   ALUResultEx, RdData2ForMem, WriteRegEX, LinkerRegisterDataEX,
//   *RegisterEX / LinkerRegEX     registered EX/MEM outputs
//   ALUZeroFlag, LTFlagRegister   combinational branch flags
// ---------------------------------------------------------------------------

module mux4to1 #(
    parameter int W = 64
) (
    input  logic [1:0]   sel_i,
    input  logic [W-1:0] in0_i,
    input  logic [W-1:0] in1_i,
    input  logic [W-1:0] in2_i,
    input  logic [W-1:0] in3_i,
    output logic [W-1:0] out_o
);
    always_comb begin
        out_o = '0;
        case (sel_i)
            2'b00:   out_o = in0_i;
            2'b01:   out_o = in1_i;
            2'b10:   out_o = in2_i;
            2'b11:   out_o = in3_i;
            default: out_o = '0;
        endcase
    end
endmodule

module mux2to1 #(
    parameter int W = 64
) (
    input  logic         sel_i,
    input  logic [W-1:0] in0_i,
    input  logic [W-1:0] in1_i,
    output logic [W-1:0] out_o
);
    assign out_o = sel_i ? in1_i : in0_i;
endmodule

module alu #(
    parameter int W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [2:0]   op_i,
    output logic [W-1:0] result_o,
    output logic         zero_o,
    output logic         negative_o,
    output logic         overflow_o
);
    logic         is_sub;
    logic [W-1:0] b_eff;
    logic [W:0]   sum_ext;
    logic         carry_out;
    logic         carry_into_msb;
    logic         add_ovf;

    // Subtract is A + ~B + 1, sharing the adder with add.
    assign is_sub         = (op_i == 3'b011);
    assign b_eff          = is_sub ? ~b_i : b_i;
    assign sum_ext        = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, is_sub};
    assign carry_out      = sum_ext[W];
    // Carry into the MSB recovered from the MSB sum bit and its operands.
    assign carry_into_msb = a_i[W-1] ^ b_eff[W-1] ^ sum_ext[W-1];
    assign add_ovf        = carry_into_msb ^ carry_out;

    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        case (op_i)
            3'b000: result_o = b_i;
            3'b010: begin
                result_o   = sum_ext[W-1:0];
                overflow_o = add_ovf;
            end
            3'b011: begin
                result_o   = sum_ext[W-1:0];
                overflow_o = add_ovf;
            end
            3'b100: result_o = a_i & b_i;
            3'b101: result_o = a_i | b_i;
            3'b110: result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
    end

    assign negative_o = result_o[W-1];
    assign zero_o     = (result_o == '0);
endmodule

module execute_stage #(
    parameter int WIDTH  = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  ReadData1,
    input  logic [WIDTH-1:0]  ReadData2,
    input  logic [WIDTH-1:0]  DataMemWB,
    input  logic [WIDTH-1:0]  WriteBackWB,
    input  logic [1:0]        ForwCntrl1,
    input  logic [1:0]        ForwCntrl2,
    input  logic              ALUSrcID,
    input  logic [WIDTH-1:0]  ImmOrDestID,
    input  logic [2:0]        ALUOp,
    input  logic [REG_AW-1:0] WriteRegID,
    input  logic [WIDTH-1:0]  LinkerRegisterDataID,
    input  logic              MemToRegRegisterID,
    input  logic              LinkerRegIdEx,
    input  logic              RegWriteRegisterID,
    input  logic              MemWriteRegisterID,
    input  logic              MemReadRegisterID,
    output logic [WIDTH-1:0]  ALUResultEx,
    output logic [WIDTH-1:0]  RdData2ForMem,
    output logic [REG_AW-1:0] WriteRegEX,
    output logic [WIDTH-1:0]  LinkerRegisterDataEX,
    output logic              MemToRegRegisterEX,
    output logic              LinkerRegEX,
    output logic              RegWriteRegisterEX,
    output logic              MemWriteRegisterEX,
    output logic              MemReadRegisterEX,
    output logic              ALUZeroFlag,
    output logic              LTFlagRegister
);
    logic [WIDTH-1:0] opa_fwd;
    logic [WIDTH-1:0] opb_fwd;
    logic [WIDTH-1:0] opb_alu;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_neg;
    logic             alu_ovf;

    mux4to1 #(.W(WIDTH)) u_fwd_a (
        .sel_i (ForwCntrl1),
        .in0_i (ReadData1),
        .in1_i (WriteBackWB),
        .in2_i (DataMemWB),
        .in3_i ({WIDTH{1'b0}}),
        .out_o (opa_fwd)
    );

    mux4to1 #(.W(WIDTH)) u_fwd_b (
        .sel_i (ForwCntrl2),
        .in0_i (ReadData2),
        .in1_i (WriteBackWB),
        .in2_i (DataMemWB),
        .in3_i ({WIDTH{1'b0}}),
        .out_o (opb_fwd)
    );

    mux2to1 #(.W(WIDTH)) u_src_b (
        .sel_i (ALUSrcID),
        .in0_i (opb_fwd),
        .in1_i (ImmOrDestID),
        .out_o (opb_alu)
    );

    alu #(.W(WIDTH)) u_alu (
        .a_i        (opa_fwd),
        .b_i        (opb_alu),
        .op_i       (ALUOp),
        .result_o   (alu_result),
        .zero_o     (alu_zero),
        .negative_o (alu_neg),
        .overflow_o (alu_ovf)
    );

    assign ALUZeroFlag    = alu_zero;
    assign LTFlagRegister = alu_neg ^ alu_ovf;

    // EX/MEM pipeline register
    logic [WIDTH-1:0]  alu_result_q, alu_result_d;
    logic [WIDTH-1:0]  store_data_q, store_data_d;
    logic [REG_AW-1:0] wreg_q,       wreg_d;
    logic [WIDTH-1:0]  link_data_q,  link_data_d;
    logic [4:0]        ctrl_q,       ctrl_d;

    assign alu_result_d = alu_result;
    assign store_data_d = opb_fwd;   // store data bypasses the immediate mux
    assign wreg_d       = WriteRegID;
    assign link_data_d  = LinkerRegisterDataID;
    assign ctrl_d       = {MemToRegRegisterID, LinkerRegIdEx, RegWriteRegisterID,
                           MemWriteRegisterID, MemReadRegisterID};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_result_q <= '0;
            store_data_q <= '0;
            wreg_q       <= '0;
            link_data_q  <= '0;
            ctrl_q       <= '0;
        end else begin
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            wreg_q       <= wreg_d;
            link_data_q  <= link_data_d;
            ctrl_q       <= ctrl_d;
        end
    end

    assign ALUResultEx          = alu_result_q;
    assign RdData2ForMem        = store_data_q;
    assign WriteRegEX           = wreg_q;
    assign LinkerRegisterDataEX = link_data_q;
    assign MemToRegRegisterEX   = ctrl_q[4];
    assign LinkerRegEX          = ctrl_q[3];
    assign RegWriteRegisterEX   = ctrl_q[2];
    assign MemWriteRegisterEX   = ctrl_q[1];
    assign MemReadRegisterEX    = ctrl_q[0];
endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] ReadData1, ReadData2, DataMemWB, WriteBackWB, ImmOrDestID;
    logic [63:0] LinkerRegisterDataID;
    logic [1:0]  ForwCntrl1, ForwCntrl2;
    logic        ALUSrcID;
    logic [2:0]  ALUOp;
    logic [4:0]  WriteRegID;
    logic        MemToRegRegisterID, LinkerRegIdEx, RegWriteRegisterID;
    logic        MemWriteRegisterID, MemReadRegisterID;
    logic [63:0] ALUResultEx, RdData2ForMem, LinkerRegisterDataEX;
    logic [4:0]  WriteRegEX;
    logic        MemToRegRegisterEX, LinkerRegEX, RegWriteRegisterEX;
    logic        MemWriteRegisterEX, MemReadRegisterEX;
    logic        ALUZeroFlag, LTFlagRegister;

    int n_checks = 0;
    int n_fail   = 0;

    execute_stage dut (
        .clk(clk), .reset_n(reset_n),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .DataMemWB(DataMemWB), .WriteBackWB(WriteBackWB),
        .ForwCntrl1(ForwCntrl1), .ForwCntrl2(ForwCntrl2),
        .ALUSrcID(ALUSrcID), .ImmOrDestID(ImmOrDestID), .ALUOp(ALUOp),
        .WriteRegID(WriteRegID), .LinkerRegisterDataID(LinkerRegisterDataID),
        .MemToRegRegisterID(MemToRegRegisterID), .LinkerRegIdEx(LinkerRegIdEx),
        .RegWriteRegisterID(RegWriteRegisterID), .MemWriteRegisterID(MemWriteRegisterID),
        .MemReadRegisterID(MemReadRegisterID),
        .ALUResultEx(ALUResultEx), .RdData2ForMem(RdData2ForMem),
        .WriteRegEX(WriteRegEX), .LinkerRegisterDataEX(LinkerRegisterDataEX),
        .MemToRegRegisterEX(MemToRegRegisterEX), .LinkerRegEX(LinkerRegEX),
        .RegWriteRegisterEX(RegWriteRegisterEX), .MemWriteRegisterEX(MemWriteRegisterEX),
        .MemReadRegisterEX(MemReadRegisterEX),
        .ALUZeroFlag(ALUZeroFlag), .LTFlagRegister(LTFlagRegister)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model, written from the operation definitions.
    function automatic logic [63:0] fwd(input logic [1:0] sel, input logic [63:0] rf);
        case (sel)
            2'd0: return rf;
            2'd1: return WriteBackWB;
            2'd2: return DataMemWB;
            default: return 64'd0;
        endcase
    endfunction

    logic [63:0] m_a, m_bf, m_b, m_res;
    logic        m_lt;

    task automatic model();
        logic signed [64:0] wide;
        m_a  = fwd(ForwCntrl1, ReadData1);
        m_bf = fwd(ForwCntrl2, ReadData2);
        m_b  = ALUSrcID ? ImmOrDestID : m_bf;
        m_res = 64'd0;
        m_lt  = 1'b0;
        case (ALUOp)
            3'd0: m_res = m_b;
            3'd2: m_res = m_a + m_b;
            3'd3: m_res = m_a - m_b;
            3'd4: m_res = m_a & m_b;
            3'd5: m_res = m_a | m_b;
            3'd6: m_res = m_a ^ m_b;
            default: m_res = 64'd0;
        endcase
        // Less-than: sign of the exact signed result for add/sub, else MSB.
        if (ALUOp == 3'd2) begin
            wide = $signed({m_a[63], m_a}) + $signed({m_b[63], m_b});
            m_lt = (wide < 0);
        end else if (ALUOp == 3'd3) begin
            m_lt = ($signed(m_a) < $signed(m_b));
        end else begin
            m_lt = m_res[63];
        end
    endtask

    // Check combinational flags, clock once, check EX/MEM outputs.
    task automatic step(input string tag);
        logic [63:0] e_res, e_st, e_lk;
        logic [4:0]  e_wr, e_ct;
        model();
        e_res = m_res; e_st = m_bf; e_lk = LinkerRegisterDataID; e_wr = WriteRegID;
        e_ct  = {MemToRegRegisterID, LinkerRegIdEx, RegWriteRegisterID,
                 MemWriteRegisterID, MemReadRegisterID};
        #1;
        check({tag, ".zero"}, 64'(ALUZeroFlag), 64'(e_res == 64'd0));
        check({tag, ".lt"},   64'(LTFlagRegister), 64'(m_lt));
        @(posedge clk); #1;
        check({tag, ".res"},  ALUResultEx, e_res);
        check({tag, ".st"},   RdData2ForMem, e_st);
        check({tag, ".wreg"}, 64'(WriteRegEX), 64'(e_wr));
        check({tag, ".link"}, LinkerRegisterDataEX, e_lk);
        check({tag, ".ctrl"}, 64'({MemToRegRegisterEX, LinkerRegEX, RegWriteRegisterEX,
                                   MemWriteRegisterEX, MemReadRegisterEX}), 64'(e_ct));
    endtask

    task automatic set_ops(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
        ReadData1 = a; ReadData2 = b; ForwCntrl1 = 2'd0; ForwCntrl2 = 2'd0;
        ALUSrcID = 1'b0; ALUOp = op;
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, ".res"},  ALUResultEx, 64'd0);
        check({tag, ".st"},   RdData2ForMem, 64'd0);
        check({tag, ".wreg"}, 64'(WriteRegEX), 64'd0);
        check({tag, ".link"}, LinkerRegisterDataEX, 64'd0);
        check({tag, ".ctrl"}, 64'({MemToRegRegisterEX, LinkerRegEX, RegWriteRegisterEX,
                                   MemWriteRegisterEX, MemReadRegisterEX}), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        ReadData1 = 64'd0; ReadData2 = 64'd0; DataMemWB = 64'd0; WriteBackWB = 64'd0;
        ImmOrDestID = 64'd0; LinkerRegisterDataID = 64'd0;
        ForwCntrl1 = 2'd0; ForwCntrl2 = 2'd0; ALUSrcID = 1'b0; ALUOp = 3'd0;
        WriteRegID = 5'd0;
        MemToRegRegisterID = 1'b0; LinkerRegIdEx = 1'b0; RegWriteRegisterID = 1'b0;
        MemWriteRegisterID = 1'b0; MemReadRegisterID = 1'b0;
        #2;
        check_regs_zero("reset");
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Immediate add
        set_ops(64'd12, 64'd0, 3'b010); ALUSrcID = 1'b1; ImmOrDestID = 64'd4; WriteRegID = 5'd12;
        step("imm_add");
        check("imm_add.16", ALUResultEx, 64'd16);
        check("imm_add.rd12", 64'(WriteRegEX), 64'd12);

        // Forwarded subtract
        set_ops(64'd1, 64'd2, 3'b011); ForwCntrl1 = 2'd1; ForwCntrl2 = 2'd2;
        WriteBackWB = 64'd99; DataMemWB = 64'd45;
        #1;
        check("fwd_sub.lt0", 64'(LTFlagRegister), 64'd0);
        check("fwd_sub.z0", 64'(ALUZeroFlag), 64'd0);
        step("fwd_sub");
        check("fwd_sub.54", ALUResultEx, 64'd54);
        check("fwd_sub.st45", RdData2ForMem, 64'd45);

        // Forward select 11 yields zero on both operands
        set_ops(64'd7, 64'd9, 3'b010); ForwCntrl1 = 2'd3; ForwCntrl2 = 2'd3;
        step("fwd_zero");
        check("fwd_zero.res", ALUResultEx, 64'd0);

        set_ops(64'd5, 64'd5, 3'b011); #1;
        check("eq.z1", 64'(ALUZeroFlag), 64'd1);
        check("eq.lt0", 64'(LTFlagRegister), 64'd0);
        step("eq");

        set_ops(64'd3, 64'd7, 3'b011); #1;
        check("lt.lt1", 64'(LTFlagRegister), 64'd1);
        step("lt");
        check("lt.res", ALUResultEx, 64'hFFFF_FFFF_FFFF_FFFC);

        set_ops(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010); #1;
        check("ovf_add.lt0", 64'(LTFlagRegister), 64'd0);
        step("ovf_add");
        check("ovf_add.res", ALUResultEx, 64'h8000_0000_0000_0000);

        set_ops(64'h8000_0000_0000_0000, 64'd1, 3'b011); #1;
        check("ovf_sub.lt1", 64'(LTFlagRegister), 64'd1);
        step("ovf_sub");

        set_ops(64'hF0F0, 64'h0FF0, 3'b100); step("and"); check("and.v", ALUResultEx, 64'h00F0);
        set_ops(64'hF0F0, 64'h0FF0, 3'b101); step("or");  check("or.v",  ALUResultEx, 64'hFFF0);
        set_ops(64'hF0F0, 64'h0FF0, 3'b110); step("xor"); check("xor.v", ALUResultEx, 64'hFF00);
        set_ops(64'hF0F0, 64'h0FF0, 3'b000); step("pass"); check("pass.v", ALUResultEx, 64'h0FF0);
        set_ops(64'hF0F0, 64'h0FF0, 3'b001); step("op1"); check("op1.v", ALUResultEx, 64'd0);
        set_ops(64'hF0F0, 64'h0FF0, 3'b111); step("op7"); check("op7.v", ALUResultEx, 64'd0);

        // Control bits, then asynchronous reset between edges
        set_ops(64'd1, 64'd2, 3'b010); WriteRegID = 5'd31; LinkerRegisterDataID = 64'd12;
        MemToRegRegisterID = 1'b1; LinkerRegIdEx = 1'b1; RegWriteRegisterID = 1'b1;
        MemWriteRegisterID = 1'b0; MemReadRegisterID = 1'b0;
        step("ctrl");
        check("ctrl.bits", 64'({MemToRegRegisterEX, LinkerRegEX, RegWriteRegisterEX,
                                MemWriteRegisterEX, MemReadRegisterEX}), 64'b11100);
        check("ctrl.pc4", LinkerRegisterDataEX, 64'd12);
        #2 reset_n = 1'b0;
        #1 check_regs_zero("async_rst");
        @(posedge clk); #1 check_regs_zero("rst_hold");
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        check("reload.res", ALUResultEx, 64'd3);
        check("reload.pc4", LinkerRegisterDataEX, 64'd12);
        check("reload.wreg", 64'(WriteRegEX), 64'd31);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            ReadData1   = {$urandom, $urandom};
            ReadData2   = {$urandom, $urandom};
            DataMemWB   = {$urandom, $urandom};
            WriteBackWB = {$urandom, $urandom};
            ImmOrDestID = {$urandom, $urandom};
            LinkerRegisterDataID = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ReadData2 = ReadData1;
            if ($urandom_range(0, 7) == 0) ReadData1 = 64'h8000_0000_0000_0000;
            ForwCntrl1 = 2'($urandom_range(0, 3));
            ForwCntrl2 = 2'($urandom_range(0, 3));
            ALUSrcID   = 1'($urandom_range(0, 1));
            ALUOp      = 3'($urandom_range(0, 7));
            WriteRegID = 5'($urandom_range(0, 31));
            {MemToRegRegisterID, LinkerRegIdEx, RegWriteRegisterID,
             MemWriteRegisterID, MemReadRegisterID} = 5'($urandom_range(0, 31));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
